// File: rtl/mem_wb_writeback.sv
// Writeback stage: MemtoReg source mux, 32-entry register file with two async read ports, retired-write counter.
// Optional WB_BYPASS_EN: write-through bypass from the writeback value onto the read ports.
module mem_wb_writeback #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite_in,
    input  logic [1:0]        MemtoReg_in,
    input  logic [DATA_W-1:0] D_MEM_read_data_in,
    input  logic [DATA_W-1:0] D_MEM_read_addr_in,
    input  logic [DATA_W-1:0] pc_plus4_in,
    input  logic [ADDR_W-1:0] MEM_WB_RegisterRd_in,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data_out,
    output logic              wb_we_out,
    output logic [CNT_W-1:0]  wb_count
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [CNT_W-1:0]  wb_count_q;
    logic [CNT_W-1:0]  wb_count_d;

    // Writeback source select; the illegal encoding yields zero and never commits.
    always_comb begin
        wb_data_out = '0;
        case (MemtoReg_in)
            2'b00:   wb_data_out = D_MEM_read_addr_in;
            2'b01:   wb_data_out = D_MEM_read_data_in;
            2'b10:   wb_data_out = pc_plus4_in;
            default: wb_data_out = '0;
        endcase
    end

    assign wb_we_out = RegWrite_in & (MemtoReg_in != 2'b11) & (MEM_WB_RegisterRd_in != '0);

    // Next-state: only the indexed entry changes, and only on an effective write.
    always_comb begin
        regs_d     = regs_q;
        wb_count_d = wb_count_q;
        if (wb_we_out) begin
            regs_d[MEM_WB_RegisterRd_in] = wb_data_out;
            wb_count_d                   = wb_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            wb_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wb_count_q <= wb_count_d;
        end
    end

    assign wb_count = wb_count_q;

    // Read ports; index 0 is hardwired to zero and is never bypassed.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != '0) begin
            rs_data = regs_q[rs_addr];
        end
        if (rt_addr != '0) begin
            rt_data = regs_q[rt_addr];
        end
`ifdef WB_BYPASS_EN
        if (wb_we_out && (rs_addr == MEM_WB_RegisterRd_in)) begin
            rs_data = wb_data_out;
        end
        if (wb_we_out && (rt_addr == MEM_WB_RegisterRd_in)) begin
            rt_data = wb_data_out;
        end
`endif
    end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Bench for mem_wb_writeback: directed vectors with literal expectations plus a per-cycle model comparison.
module tb_mem_wb_writeback;

    logic        clk;
    logic        rst;
    logic        RegWrite_in;
    logic [1:0]  MemtoReg_in;
    logic [31:0] D_MEM_read_data_in;
    logic [31:0] D_MEM_read_addr_in;
    logic [31:0] pc_plus4_in;
    logic [4:0]  MEM_WB_RegisterRd_in;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data_out;
    logic        wb_we_out;
    logic [31:0] wb_count;

    mem_wb_writeback dut (
        .clk                 (clk),
        .rst                 (rst),
        .RegWrite_in         (RegWrite_in),
        .MemtoReg_in         (MemtoReg_in),
        .D_MEM_read_data_in  (D_MEM_read_data_in),
        .D_MEM_read_addr_in  (D_MEM_read_addr_in),
        .pc_plus4_in         (pc_plus4_in),
        .MEM_WB_RegisterRd_in(MEM_WB_RegisterRd_in),
        .rs_addr             (rs_addr),
        .rt_addr             (rt_addr),
        .rs_data             (rs_data),
        .rt_data             (rt_data),
        .wb_data_out         (wb_data_out),
        .wb_we_out           (wb_we_out),
        .wb_count            (wb_count)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_wb();
        if (MemtoReg_in == 2'd0) return D_MEM_read_addr_in;
        if (MemtoReg_in == 2'd1) return D_MEM_read_data_in;
        if (MemtoReg_in == 2'd2) return pc_plus4_in;
        return 32'h0;
    endfunction

    function automatic logic exp_we();
        return RegWrite_in && (MemtoReg_in != 2'd3) && (MEM_WB_RegisterRd_in != 5'd0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (exp_we() && a == MEM_WB_RegisterRd_in) return exp_wb();
`endif
        return m_regs[a];
    endfunction

    // Behavioural model state: cleared while reset is high, updated on each committing edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_cnt = 32'h0;
        end else if (exp_we()) begin
            m_regs[MEM_WB_RegisterRd_in] = exp_wb();
            m_cnt = m_cnt + 32'd1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rs_data", rs_data, exp_read(rs_addr));
            chk("rt_data", rt_data, exp_read(rt_addr));
            chk("wb_data_out", wb_data_out, exp_wb());
            chk("wb_we_out", 32'(wb_we_out), 32'(exp_we()));
            chk("wb_count", wb_count, m_cnt);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] sel, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] mdat, input logic [31:0] pc);
        RegWrite_in          = we;
        MemtoReg_in          = sel;
        MEM_WB_RegisterRd_in = rd;
        D_MEM_read_addr_in   = alu;
        D_MEM_read_data_in   = mdat;
        pc_plus4_in          = pc;
    endtask

    initial begin
        int unsigned seed_r;
        rst = 1'b1;
        drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        repeat (2) next();
        chk("reset_count", wb_count, 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Source select into r3
        rs_addr = 5'd3;
        drive(1'b1, 2'd0, 5'd3, 32'hAAAA0001, 32'h55550002, 32'h00400008);
        next();
        RegWrite_in = 1'b0;
        #1 chk("sel_alu", rs_data, 32'hAAAA0001);
        drive(1'b1, 2'd1, 5'd3, 32'hAAAA0001, 32'h55550002, 32'h00400008);
        next();
        RegWrite_in = 1'b0;
        #1 chk("sel_mem", rs_data, 32'h55550002);
        drive(1'b1, 2'd2, 5'd3, 32'hAAAA0001, 32'h55550002, 32'h00400008);
        next();
        RegWrite_in = 1'b0;
        #1 chk("sel_pc", rs_data, 32'h00400008);
        chk("count_3", wb_count, 32'd3);

        // Illegal select and Rd=0
        rs_addr = 5'd7;
        drive(1'b1, 2'd3, 5'd7, 32'h77777777, 32'h77777777, 32'h77777777);
        #1 chk("illegal_we", 32'(wb_we_out), 32'd0);
        chk("illegal_data", wb_data_out, 32'h0);
        next();
        RegWrite_in = 1'b0;
        #1 chk("illegal_r7", rs_data, 32'h0);
        chk("illegal_count", wb_count, 32'd3);
        rs_addr = 5'd0;
        drive(1'b1, 2'd1, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        #1 chk("rd0_we", 32'(wb_we_out), 32'd0);
        next();
        RegWrite_in = 1'b0;
        #1 chk("rd0_read", rs_data, 32'h0);
        chk("rd0_count", wb_count, 32'd3);

        // Bypass on r9
        drive(1'b1, 2'd0, 5'd9, 32'h11110009, 32'h0, 32'h0);
        next();
        rs_addr = 5'd9;
        rt_addr = 5'd9;
        drive(1'b1, 2'd0, 5'd9, 32'hCAFEF00D, 32'h0, 32'h0);
`ifdef WB_BYPASS_EN
        #1 chk("byp_rs_pre", rs_data, 32'hCAFEF00D);
        chk("byp_rt_pre", rt_data, 32'hCAFEF00D);
`else
        #1 chk("byp_rs_pre", rs_data, 32'h11110009);
        chk("byp_rt_pre", rt_data, 32'h11110009);
`endif
        next();
        RegWrite_in = 1'b0;
        #1 chk("byp_rs_post", rs_data, 32'hCAFEF00D);
        chk("byp_rt_post", rt_data, 32'hCAFEF00D);
        chk("byp_count", wb_count, 32'd5);

        // Mid-cycle asynchronous reset after r5 = 0x1234
        rs_addr = 5'd5;
        drive(1'b1, 2'd0, 5'd5, 32'h00001234, 32'h0, 32'h0);
        next();
        RegWrite_in = 1'b0;
        #1 chk("r5_before_rst", rs_data, 32'h00001234);
        rst = 1'b1;
        #1 chk("async_rst_r5", rs_data, 32'h0);
        chk("async_rst_count", wb_count, 32'h0);
        rt_addr = 5'd3;
        #1 chk("async_rst_r3", rt_data, 32'h0);

        // Write attempted across an edge while reset is high
        rs_addr = 5'd4;
        drive(1'b1, 2'd0, 5'd4, 32'h00000044, 32'h0, 32'h0);
        next();
        rst = 1'b0;
        RegWrite_in = 1'b0;
        #1 chk("rst_edge_r4", rs_data, 32'h0);
        chk("rst_edge_count", wb_count, 32'h0);
        RegWrite_in = 1'b1;
        next();
        RegWrite_in = 1'b0;
        #1 chk("release_r4", rs_data, 32'h00000044);
        chk("release_count", wb_count, 32'd1);

        // Random soak, seed 1
        seed_r = $urandom(1);
        for (int n = 0; n < 2000; n++) begin
            RegWrite_in          = 1'($urandom);
            MemtoReg_in          = 2'($urandom);
            MEM_WB_RegisterRd_in = 5'($urandom);
            D_MEM_read_addr_in   = $urandom;
            D_MEM_read_data_in   = $urandom;
            pc_plus4_in          = $urandom;
            rs_addr              = 5'($urandom);
            rt_addr              = 5'($urandom);
            next();
        end
        @(negedge clk);
        chk_en = 1'b0;
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
Consumer end of the MEM/WB pipeline register, i.e. the writeback stage. It selects the writeback value from the MEM/WB outputs according to MemtoReg and commits it into a 32x32 architectural register file. It supplies two asynchronous read ports to the ID stage and keeps a retired-write counter for debug and benches.

Parameters:
DATA_W, 32, register and data width
ADDR_W, 5, register index width (2**ADDR_W registers)
CNT_W, 32, width of the retired-write counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
RegWrite_in  input  1  write enable from MEM/WB
MemtoReg_in  input  2  writeback source select from MEM/WB
D_MEM_read_data_in  input  DATA_W  load data from MEM/WB
D_MEM_read_addr_in  input  DATA_W  ALU result / memory address from MEM/WB
pc_plus4_in  input  DATA_W  link value (PC+4) carried down the pipe
MEM_WB_RegisterRd_in  input  ADDR_W  destination register index
rs_addr  input  ADDR_W  read port A index
rt_addr  input  ADDR_W  read port B index
rs_data  output  DATA_W  read port A data
rt_data  output  DATA_W  read port B data
wb_data_out  output  DATA_W  selected writeback value, also for the forwarding unit
wb_we_out  output  1  effective write enable this cycle
wb_count  output  CNT_W  number of committed register writes since reset

Behaviour:
- Source mux, combinational: MemtoReg 00 -> D_MEM_read_addr_in (ALU result); 01 -> D_MEM_read_data_in; 10 -> pc_plus4_in; 11 -> illegal, wb_data_out = 0.
- Effective write: wb_we_out = RegWrite_in & (MemtoReg_in != 11) & (MEM_WB_RegisterRd_in != 0).
- Commit: on posedge clk with rst low and wb_we_out=1, regs[Rd] <= wb_data_out. One-cycle latency: value is visible on read ports in the cycle after the edge.
- Register 0: always reads 0. Writes to it are discarded and not counted.
- Reads: rs_data/rt_data are combinational from the array. Index 0 returns 0. Both ports may address the same register.
- Counter: wb_count increments by 1 on each committing edge. It wraps from 2**CNT_W-1 to 0 with no saturation.
- Reset (asynchronous, any time): all 32 registers and wb_count clear to 0 immediately, without waiting for an edge. A write coincident with a rising edge while rst is high is discarded. Read outputs reflect the cleared array during reset. wb_data_out and wb_we_out stay combinational from the inputs during reset.
- Reset release: the first commit can occur on the first rising edge with rst low.
- X-safety: an undriven MemtoReg or Rd must not corrupt other registers. Only the indexed entry may change.

Optional Feature:
WB_BYPASS_EN
- Defined: write-through bypass. When wb_we_out=1 and rs_addr==MEM_WB_RegisterRd_in, rs_data = wb_data_out in the same cycle, before the edge. The same rule applies to rt_addr/rt_data. This removes the WB->ID hazard, so the hazard unit needs no extra stall.
- Undefined: reads return array contents only. The newly written value appears the cycle after the commit edge.
- Rd=0 is never bypassed in either build.

Test Plan:
- Reset: pulse rst mid-cycle (not at a clock edge) after regs[5]=0x1234 -> rs_addr=5 reads 0 immediately and wb_count=0, with no clock edge required.
- Source select: Rd=3, RegWrite=1. MemtoReg=00/ALU=0xAAAA0001 -> regs[3]=0xAAAA0001. MemtoReg=01/data=0x5555_0002 -> regs[3]=0x55550002. MemtoReg=10/pc=0x00400008 -> regs[3]=0x00400008. wb_count=3.
- Illegal/zero: MemtoReg=11, Rd=7, RegWrite=1 -> wb_we_out=0, regs[7] unchanged, wb_count unchanged. Rd=0 with data 0xFFFFFFFF -> rs_addr=0 reads 0.
- Bypass: Rd=9, ALU=0xCAFEF00D, rs_addr=rt_addr=9 before the edge -> with WB_BYPASS_EN both ports read 0xCAFEF00D that cycle. Without the macro they read the old value, then 0xCAFEF00D after the edge.
- Reset at edge: rst high across a posedge with RegWrite=1, Rd=4 -> regs[4]=0 after release, wb_count=0.
- Random soak: 2000 cycles of seeded random inputs (seed=1) vs a behavioural model array -> all reads and wb_count match every cycle.
